// File: rtl/tcdm_rob_adapter_pkg.sv
// Shared types and default sizing for the tile-side TCDM port fan-out with read reorder buffer.
package tcdm_rob_adapter_pkg;
  localparam int unsigned DefNumPorts       = 4;
  localparam int unsigned DefMaxOutstanding = 8;
  localparam int unsigned DefPortSelOffset  = 2;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  be_t;
  typedef logic [$clog2(DefMaxOutstanding)-1:0] rob_idx_t;
endpackage

// File: rtl/tcdm_rob_adapter_fifo.sv
// Small synchronous FIFO holding ROB indices of reads outstanding on one interconnect port.
module tcdm_rob_adapter_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr, rptr;
  logic [PtrW:0]    cnt;
  logic             push_ok, pop_ok;

  assign full    = (cnt == (PtrW+1)'(Depth));
  assign empty   = (cnt == '0);
  assign rdata   = mem[rptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (pop_ok) rptr <= rptr + 1'b1;
      cnt <= cnt + {{PtrW{1'b0}}, push_ok} - {{PtrW{1'b0}}, pop_ok};
    end
  end
endmodule

// File: rtl/tcdm_rob_adapter.sv
// Steers core requests to one of NumPorts interconnect ports and returns read data in issue
// order through a reorder buffer shared by all ports.
module tcdm_rob_adapter
  import tcdm_rob_adapter_pkg::*;
#(
  parameter int unsigned NumPorts       = DefNumPorts,
  parameter int unsigned MaxOutstanding = DefMaxOutstanding,
  parameter int unsigned PortSelOffset  = DefPortSelOffset
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       core_req_i,
  input  addr_t                      core_addr_i,
  input  logic                       core_wen_i,
  input  data_t                      core_wdata_i,
  input  be_t                        core_be_i,
  output logic                       core_gnt_o,
  output logic                       core_vld_o,
  output data_t                      core_rdata_o,
  output logic  [NumPorts-1:0]       port_req_o,
  output addr_t [NumPorts-1:0]       port_addr_o,
  output logic  [NumPorts-1:0]       port_wen_o,
  output data_t [NumPorts-1:0]       port_wdata_o,
  output be_t   [NumPorts-1:0]       port_be_o,
  input  logic  [NumPorts-1:0]       port_gnt_i,
  input  logic  [NumPorts-1:0]       port_vld_i,
  input  data_t [NumPorts-1:0]       port_rdata_i
);
  localparam int unsigned SelW = $clog2(NumPorts);
  localparam int unsigned IdxW = $clog2(MaxOutstanding);
  typedef logic [IdxW-1:0] idx_t;

  logic [SelW-1:0]              sel;
  logic [NumPorts-1:0]          fifo_full, fifo_empty, fifo_push, fifo_pop;
  idx_t [NumPorts-1:0]          fifo_head;
  logic [MaxOutstanding-1:0]    rob_valid;
  data_t                        rob_data [MaxOutstanding];
  idx_t                         head, tail;
  logic [IdxW:0]                count;
  logic                         rob_full, space, rd_alloc, retire;

  assign sel      = core_addr_i[PortSelOffset +: SelW];
  assign rob_full = (count == (IdxW+1)'(MaxOutstanding));
  // Writes never produce a response, so they bypass all ROB bookkeeping.
  assign space    = core_wen_i | (~rob_full & ~fifo_full[sel]);

  always_comb begin
    port_req_o      = '0;
    port_req_o[sel] = core_req_i & space;
  end

  assign core_gnt_o   = port_req_o[sel] & port_gnt_i[sel];
  assign rd_alloc     = core_gnt_o & ~core_wen_i;
  assign retire       = rob_valid[head] & (count != '0);
  assign core_vld_o   = retire;
  assign core_rdata_o = rob_data[head];

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    assign port_addr_o[p]  = core_addr_i;
    assign port_wen_o[p]   = core_wen_i;
    assign port_wdata_o[p] = core_wdata_i;
    assign port_be_o[p]    = core_be_i;
    assign fifo_push[p]    = rd_alloc & (sel == SelW'(p));
    assign fifo_pop[p]     = port_vld_i[p] & ~fifo_empty[p];

    tcdm_rob_adapter_fifo #(
      .Depth (MaxOutstanding),
      .Width (IdxW)
    ) i_id_fifo (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .push  (fifo_push[p]),
      .wdata (tail),
      .pop   (fifo_pop[p]),
      .rdata (fifo_head[p]),
      .full  (fifo_full[p]),
      .empty (fifo_empty[p])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rob_valid <= '0;
      for (int i = 0; i < int'(MaxOutstanding); i++) rob_data[i] <= '0;
    end else begin
      if (retire) begin
        rob_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      if (rd_alloc) begin
        rob_valid[tail] <= 1'b0;
        tail            <= tail + 1'b1;
      end
      // Responding slots are never head-retiring or newly allocated, so these writes don't collide.
      for (int p = 0; p < int'(NumPorts); p++) begin
        if (fifo_pop[p]) begin
          rob_valid[fifo_head[p]] <= 1'b1;
          rob_data[fifo_head[p]]  <= port_rdata_i[p];
        end
      end
      count <= count + {{IdxW{1'b0}}, rd_alloc} - {{IdxW{1'b0}}, retire};
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int p = 0; p < int'(NumPorts); p++) begin
        assert (!(port_vld_i[p] && fifo_empty[p]))
          else $error("response on port %0d with no read outstanding", p);
        assert (!(fifo_pop[p] && rob_valid[fifo_head[p]]))
          else $error("response on port %0d overwrites a valid ROB entry", p);
      end
    end
  end
`endif
endmodule

// File: tb/tb_tcdm_rob_adapter.sv
// Bench for tcdm_rob_adapter: issue-order transaction model plus directed and random traffic.
module tb_tcdm_rob_adapter;
  import tcdm_rob_adapter_pkg::*;

  localparam int NP  = 4;
  localparam int MO  = 8;
  localparam int OFF = 2;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  logic                 core_req, core_wen, core_gnt, core_vld;
  addr_t                core_addr;
  data_t                core_wdata, core_rdata;
  be_t                  core_be;
  logic  [NP-1:0]       port_req, port_wen, port_gnt, port_vld;
  addr_t [NP-1:0]       port_addr;
  data_t [NP-1:0]       port_wdata, port_rdata;
  be_t   [NP-1:0]       port_be;

  tcdm_rob_adapter #(.NumPorts(NP), .MaxOutstanding(MO), .PortSelOffset(OFF)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .core_req_i  (core_req),
    .core_addr_i (core_addr),
    .core_wen_i  (core_wen),
    .core_wdata_i(core_wdata),
    .core_be_i   (core_be),
    .core_gnt_o  (core_gnt),
    .core_vld_o  (core_vld),
    .core_rdata_o(core_rdata),
    .port_req_o  (port_req),
    .port_addr_o (port_addr),
    .port_wen_o  (port_wen),
    .port_wdata_o(port_wdata),
    .port_be_o   (port_be),
    .port_gnt_i  (port_gnt),
    .port_vld_i  (port_vld),
    .port_rdata_i(port_rdata)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: reads in issue order; each port owns a queue of its unanswered reads.
  int unsigned iss_q[$];
  int unsigned pq[NP][$];
  bit          fin[int];
  data_t       fdat[int];
  int unsigned seq = 0;

  int           m_sel;
  bit           m_space, m_gnt, m_vld;
  logic [NP-1:0] m_req;

  always @(negedge clk) begin
    if (rst_ni !== 1'b1) begin
      iss_q.delete();
      for (int p = 0; p < NP; p++) pq[p].delete();
      fin.delete();
      fdat.delete();
    end else begin
      m_sel   = int'(core_addr[OFF +: 2]);
      m_space = core_wen || (iss_q.size() < MO && pq[m_sel].size() < MO);
      m_req   = '0;
      if (core_req && m_space) m_req[m_sel] = 1'b1;
      m_gnt   = m_req[m_sel] && port_gnt[m_sel];
      m_vld   = iss_q.size() > 0 && fin.exists(int'(iss_q[0]));
      chk("port_req", port_req, m_req);
      chk("core_gnt", core_gnt, m_gnt);
      chk("core_vld", core_vld, m_vld);
      if (m_vld) chk("core_rdata", core_rdata, fdat[int'(iss_q[0])]);
      if (core_req) chk("port_addr", port_addr[m_sel], core_addr);
      if (m_vld) begin
        fin.delete(int'(iss_q[0]));
        fdat.delete(int'(iss_q[0]));
        void'(iss_q.pop_front());
      end
      if (m_gnt && !core_wen) begin
        iss_q.push_back(seq);
        pq[m_sel].push_back(seq);
        seq++;
      end
      for (int p = 0; p < NP; p++) begin
        if (port_vld[p] && pq[p].size() > 0) begin
          int id;
          id       = int'(pq[p].pop_front());
          fin[id]  = 1'b1;
          fdat[id] = port_rdata[p];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req = 1'b0;
    core_wen = 1'b0;
    port_vld = '0;
  endtask

  task automatic req(input int p, input bit wen);
    addr_t a;
    a           = addr_t'($urandom);
    a[OFF +: 2] = 2'(p);
    a[1:0]      = 2'b00;
    core_req    = 1'b1;
    core_wen    = wen;
    core_addr   = a;
    core_wdata  = data_t'($urandom);
    core_be     = be_t'($urandom);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    idle();
    while (iss_q.size() > 0 && cyc < 60) begin
      for (int p = 0; p < NP; p++) begin
        port_vld[p]   = (pq[p].size() > 0);
        port_rdata[p] = data_t'($urandom);
      end
      tick();
      cyc++;
    end
    port_vld = '0;
    tick();
    chk("drained", 64'(iss_q.size()), 64'd0);
  endtask

  initial begin
    rst_ni     = 1'b0;
    port_gnt   = '1;
    port_rdata = '0;
    core_addr  = '0;
    core_wdata = '0;
    core_be    = '0;
    idle();
    tick(); tick();
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst vld", core_vld, 1'b0);
    chk("rst rdata", core_rdata, 32'h0);
    chk("rst req", port_req, 4'b0000);
    tick();

    // Out-of-order return across ports
    req(0, 1'b0);
    @(negedge clk); chk("A gnt", core_gnt, 1'b1); chk("A req", port_req, 4'b0001);
    tick();
    req(1, 1'b0);
    @(negedge clk); chk("B req", port_req, 4'b0010);
    tick();
    idle(); port_vld = 4'b0010; port_rdata[1] = 32'hBBBB;
    @(negedge clk); chk("B early vld", core_vld, 1'b0);
    tick();
    port_vld = 4'b0001; port_rdata[0] = 32'hAAAA;
    @(negedge clk); chk("A wait vld", core_vld, 1'b0);
    tick();
    port_vld = '0;
    @(negedge clk); chk("A out", core_rdata, 32'hAAAA); chk("A vld", core_vld, 1'b1);
    tick();
    @(negedge clk); chk("B out", core_rdata, 32'hBBBB); chk("B vld", core_vld, 1'b1);
    tick();
    @(negedge clk); chk("AB done", core_vld, 1'b0);
    tick();

    // Fill the ROB, then full-ROB behaviour and tail wrap
    for (int i = 0; i < MO; i++) begin
      req(i % NP, 1'b0);
      @(negedge clk); chk("fill gnt", core_gnt, 1'b1);
      tick();
    end
    req(1, 1'b0);
    @(negedge clk); chk("full rd gnt", core_gnt, 1'b0); chk("full rd req", port_req, 4'b0000);
    tick();
    req(2, 1'b1);
    @(negedge clk); chk("full wr gnt", core_gnt, 1'b1);
    tick();
    req(1, 1'b0); port_vld = 4'b0001; port_rdata[0] = 32'h1111;
    @(negedge clk); chk("full rd gnt2", core_gnt, 1'b0);
    tick();
    port_vld = '0;
    @(negedge clk);
    chk("retire vld", core_vld, 1'b1); chk("retire data", core_rdata, 32'h1111);
    chk("retire-cycle gnt", core_gnt, 1'b0);
    tick();
    @(negedge clk); chk("post-retire gnt", core_gnt, 1'b1);
    tick();
    drain();

    // All ports respond together
    for (int i = 0; i < NP; i++) begin
      req(i, 1'b0);
      @(negedge clk); chk("quad gnt", core_gnt, 1'b1);
      tick();
    end
    idle(); port_vld = '1;
    for (int p = 0; p < NP; p++) port_rdata[p] = data_t'(32'h1000 + p);
    tick();
    port_vld = '0;
    for (int i = 0; i < NP; i++) begin
      @(negedge clk);
      chk("quad vld", core_vld, 1'b1);
      chk("quad data", core_rdata, 64'(32'h1000 + i));
      tick();
    end
    @(negedge clk); chk("quad done", core_vld, 1'b0);
    tick();

    // Reset with reads in flight; late responses land while reset is held
    for (int i = 0; i < 5; i++) begin
      req(i % NP, 1'b0);
      tick();
    end
    idle();
    rst_ni = 1'b0; port_vld = '1;
    for (int p = 0; p < NP; p++) port_rdata[p] = 32'hDEAD;
    tick(); tick();
    port_vld = '0; rst_ni = 1'b1;
    @(negedge clk); chk("post-rst rdata", core_rdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("post-rst vld", core_vld, 1'b0);
      tick();
    end
    req(2, 1'b0);
    @(negedge clk); chk("post-rst gnt", core_gnt, 1'b1);
    tick();
    idle(); port_vld = 4'b0100; port_rdata[2] = 32'h5555;
    tick();
    port_vld = '0;
    @(negedge clk); chk("post-rst vld1", core_vld, 1'b1); chk("post-rst data", core_rdata, 32'h5555);
    tick();

    // Random traffic against the model
    for (int c = 0; c < 1000; c++) begin
      if ($urandom_range(0, 3) != 0) req(int'($urandom_range(0, NP-1)), ($urandom_range(0, 3) == 0));
      else core_req = 1'b0;
      for (int p = 0; p < NP; p++) begin
        port_gnt[p]   = ($urandom_range(0, 3) != 0);
        port_vld[p]   = (pq[p].size() > 0) && ($urandom_range(0, 2) == 0);
        port_rdata[p] = data_t'($urandom);
      end
      tick();
    end
    port_gnt = '1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
